// File: rtl/div_ctrl.sv
// div_ctrl: SIMT branch-divergence controller. It turns branch and join
// instructions into push/pop/complement commands for an external predicate
// stack (pstack) and issues PC redirects for the taken and else paths.
// Per nesting level it keeps the else-path PC and a THEN/ELSE phase bit.

`ifndef N_CORES
`define N_CORES 4
`endif

module div_ctrl #(
  parameter int N_CORES = `N_CORES,
  parameter int PC_W    = 8,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       br_valid,
  input  logic [N_CORES-1:0]         br_pred,
  input  logic [PC_W-1:0]            br_target,
  input  logic [PC_W-1:0]            br_fall,
  input  logic                       join_valid,
  input  logic [N_CORES-1:0]         ps_q,
  output logic [N_CORES-1:0]         ps_d,
  output logic                       ps_push,
  output logic                       ps_pop,
  output logic                       ps_comp,
  output logic                       pc_redir_valid,
  output logic [PC_W-1:0]            pc_redir,
  output logic [N_CORES-1:0]         active_mask,
  output logic                       stall,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       err
);

  localparam int DW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {S_IDLE, S_OP, S_SETTLE} state_t;

  state_t              r_state;
  logic [PC_W-1:0]     r_fall [DEPTH];
  logic [DEPTH-1:0]    r_phase;        // 0 = THEN path running, 1 = ELSE path running
  logic [N_CORES-1:0]  r_ps_d;
  logic                r_push;
  logic                r_pop;
  logic                r_comp;
  logic                r_rv;
  logic [PC_W-1:0]     r_pc;
  logic                r_stall;
  logic [DW-1:0]       r_depth;
  logic                r_err;

  logic [N_CORES-1:0]  w_active_mask;
  logic [N_CORES-1:0]  w_taken;
  logic                w_top_phase;
  logic [PC_W-1:0]     w_top_fall;

  // Outside any divergent region every lane runs; inside, the stack top decides.
  always_comb begin
    w_active_mask = (r_depth == '0) ? '1 : ps_q;
    w_taken       = br_pred & w_active_mask;
  end

  // Select the saved phase and else-PC of the innermost open level (depth-1).
  always_comb begin
    w_top_phase = 1'b0;
    w_top_fall  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_depth == DW'(i + 1)) begin
        w_top_phase = r_phase[i];
        w_top_fall  = r_fall[i];
      end
    end
  end

  // Controller FSM: decodes branch/join in IDLE, issues one command in OP,
  // then SETTLE gives the stack a cycle before the next instruction is sampled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_ps_d  <= '0;
      r_push  <= 1'b0;
      r_pop   <= 1'b0;
      r_comp  <= 1'b0;
      r_rv    <= 1'b0;
      r_pc    <= '0;
      r_stall <= 1'b0;
      r_depth <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_fall[i] <= '0;
    end else begin
      // command and redirect strobes are single-cycle by default
      r_push <= 1'b0;
      r_pop  <= 1'b0;
      r_comp <= 1'b0;
      r_rv   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (br_valid && join_valid) begin
            // ambiguous instruction: act on neither
            r_err <= 1'b1;
          end else if (br_valid) begin
            if (w_taken == w_active_mask) begin
              // every active lane agrees: plain jump, stack untouched
              r_rv <= 1'b1;
              r_pc <= br_target;
            end else if (w_taken == '0) begin
              // no active lane takes the branch: fall through silently
            end else if (r_depth == DW'(DEPTH)) begin
              // no room for another nesting level
              r_err <= 1'b1;
            end else begin
              r_state <= S_OP;
              r_stall <= 1'b1;
              r_push  <= 1'b1;
              r_ps_d  <= w_taken;
              r_rv    <= 1'b1;
              r_pc    <= br_target;
              for (int i = 0; i < DEPTH; i++) begin
                if (r_depth == DW'(i)) begin
                  r_fall[i]  <= br_fall;
                  r_phase[i] <= 1'b0;
                end
              end
            end
          end else if (join_valid) begin
            if (r_depth == '0) begin
              // join with nothing open
              r_err <= 1'b1;
            end else begin
              r_state <= S_OP;
              r_stall <= 1'b1;
              if (!w_top_phase) begin
                // THEN path finished: flip to the else lanes and jump there
                r_comp <= 1'b1;
                r_rv   <= 1'b1;
                r_pc   <= w_top_fall;
                for (int i = 0; i < DEPTH; i++) begin
                  if (r_depth == DW'(i + 1)) r_phase[i] <= 1'b1;
                end
              end else begin
                // ELSE path finished: close the level, execution continues in line
                r_pop <= 1'b1;
              end
            end
          end
        end
        S_OP: begin
          r_state <= S_SETTLE;
          if (r_push)     r_depth <= r_depth + 1'b1;
          else if (r_pop) r_depth <= r_depth - 1'b1;
        end
        S_SETTLE: begin
          r_state <= S_IDLE;
          r_stall <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  assign ps_d           = r_ps_d;
  assign ps_push        = r_push;
  assign ps_pop         = r_pop;
  assign ps_comp        = r_comp;
  assign pc_redir_valid = r_rv;
  assign pc_redir       = r_pc;
  assign active_mask    = w_active_mask;
  assign stall          = r_stall;
  assign depth          = r_depth;
  assign err            = r_err;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: drives branch/join instructions into div_ctrl with a
// behavioural predicate stack attached; expected command/redirect records are
// queued at stimulus time and matched when the controller emits them.

module tb_div_ctrl;

  localparam int N  = 4;
  localparam int PW = 8;
  localparam int D  = 4;
  localparam int DW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          br_valid;
  logic [N-1:0]  br_pred;
  logic [PW-1:0] br_target;
  logic [PW-1:0] br_fall;
  logic          join_valid;
  logic [N-1:0]  ps_q;
  logic [N-1:0]  ps_d;
  logic          ps_push, ps_pop, ps_comp;
  logic          pc_redir_valid;
  logic [PW-1:0] pc_redir;
  logic [N-1:0]  active_mask;
  logic          stall;
  logic [DW-1:0] depth;
  logic          err;

  always #5 clk = ~clk;

  div_ctrl #(.N_CORES(N), .PC_W(PW), .DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .br_valid(br_valid), .br_pred(br_pred), .br_target(br_target), .br_fall(br_fall),
    .join_valid(join_valid), .ps_q(ps_q), .ps_d(ps_d),
    .ps_push(ps_push), .ps_pop(ps_pop), .ps_comp(ps_comp),
    .pc_redir_valid(pc_redir_valid), .pc_redir(pc_redir),
    .active_mask(active_mask), .stall(stall), .depth(depth), .err(err)
  );

  // Behavioural pstack following the push/pop/complement contract.
  logic [N-1:0] stk [D+1];
  int           sp;
  logic [N-1:0] model_top;
  logic         frc_en;
  logic [N-1:0] frc_val;

  always @(posedge clk) begin
    if (reset) sp <= 0;
    else if (ps_push && sp <= D) begin
      stk[sp] <= ps_d;
      sp <= sp + 1;
    end else if (ps_pop && sp > 0) sp <= sp - 1;
    else if (ps_comp && sp > 0) stk[sp-1] <= ((sp >= 2) ? stk[sp-2] : {N{1'b1}}) & ~stk[sp-1];
  end

  always_comb begin
    model_top = (sp == 0) ? '0 : stk[sp-1];
    // frc_en substitutes a fixed stack top so nesting can exceed what 4 lanes allow
    ps_q = frc_en ? frc_val : model_top;
  end

  typedef struct packed {
    logic          rv;
    logic [PW-1:0] pc;
    logic          push;
    logic          pop;
    logic          comp;
    logic [N-1:0]  psd;
  } out_t;

  typedef struct packed {
    logic          br;
    logic          jn;
    logic [N-1:0]  pred;
    logic [PW-1:0] tgt;
    logic [PW-1:0] fall;
    logic          has_out;
    out_t          o;
    int            stall_n;
    logic [DW-1:0] dep;
    logic [N-1:0]  mask;
    logic          err;
  } vec_t;

  out_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   vnum  = 0;

  function automatic vec_t mk(input logic br, input logic jn, input logic [N-1:0] pred,
                              input logic [PW-1:0] tgt, input logic [PW-1:0] fall,
                              input logic has, input logic rv, input logic [PW-1:0] pc,
                              input logic push, input logic pop, input logic comp,
                              input logic [N-1:0] psd, input int stall_n,
                              input logic [DW-1:0] dep, input logic [N-1:0] mask,
                              input logic e_err);
    vec_t v;
    v.br = br; v.jn = jn; v.pred = pred; v.tgt = tgt; v.fall = fall;
    v.has_out = has;
    v.o.rv = rv; v.o.pc = pc; v.o.push = push; v.o.pop = pop; v.o.comp = comp; v.o.psd = psd;
    v.stall_n = stall_n; v.dep = dep; v.mask = mask; v.err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Match any emitted command/redirect against the oldest expected record.
  task automatic monitor();
    out_t a, e;
    if (pc_redir_valid || ps_push || ps_pop || ps_comp) begin
      chk("onehot_cmd", int'(ps_push) + int'(ps_pop) + int'(ps_comp) <= 1, 1);
      a.rv = pc_redir_valid; a.pc = pc_redir_valid ? pc_redir : '0;
      a.push = ps_push; a.pop = ps_pop; a.comp = ps_comp;
      a.psd = ps_push ? ps_d : '0;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_output: got rv=%0b pc=%h push=%0b pop=%0b comp=%0b expected none",
                 a.rv, a.pc, a.push, a.pop, a.comp);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          fails++;
          $display("[TB] FAIL output: got rv=%0b pc=%h push=%0b pop=%0b comp=%0b d=%b expected rv=%0b pc=%h push=%0b pop=%0b comp=%0b d=%b",
                   a.rv, a.pc, a.push, a.pop, a.comp, a.psd, e.rv, e.pc, e.push, e.pop, e.comp, e.psd);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    monitor();
  endtask

  task automatic do_reset();
    reset = 1'b1; br_valid = 1'b0; join_valid = 1'b0; frc_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic apply_vec(input vec_t v);
    int n;
    br_valid = v.br; join_valid = v.jn; br_pred = v.pred; br_target = v.tgt; br_fall = v.fall;
    if (v.has_out) sb.push_back(v.o);
    tick();
    br_valid = 1'b0; join_valid = 1'b0;
    n = 0;
    while (stall === 1'b1 && n < 8) begin
      n++;
      tick();
    end
    chk("stall_cycles", n, v.stall_n);
    chk("depth", depth, v.dep);
    chk("active_mask", active_mask, v.mask);
    chk("err", err, v.err);
    chk("output_missing", sb.size(), 0);
    $display("[TB] vec %0d br=%0b jn=%0b pred=%b tgt=%h -> depth=%0d mask=%b err=%0b stall=%0d",
             vnum, v.br, v.jn, v.pred, v.tgt, depth, active_mask, err, n);
    vnum++;
  endtask

  vec_t vt[12];

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation ran past its time limit");
    $fatal(1);
  end

  initial begin
    br_pred = '0; br_target = '0; br_fall = '0; frc_val = '0;
    vt[0]  = mk(1,0,4'b1111,8'h20,8'h00, 1, 1,8'h20,0,0,0,4'b0000, 0,0,4'b1111,0);
    vt[1]  = mk(1,0,4'b0000,8'h30,8'h34, 0, 0,8'h00,0,0,0,4'b0000, 0,0,4'b1111,0);
    vt[2]  = mk(1,0,4'b1010,8'h10,8'h08, 1, 1,8'h10,1,0,0,4'b1010, 2,1,4'b1010,0);
    vt[3]  = mk(0,1,4'b0000,8'h00,8'h00, 1, 1,8'h08,0,0,1,4'b0000, 2,1,4'b0101,0);
    vt[4]  = mk(0,1,4'b0000,8'h00,8'h00, 1, 0,8'h00,0,1,0,4'b0000, 2,0,4'b1111,0);
    vt[5]  = mk(1,0,4'b1100,8'h40,8'h44, 1, 1,8'h40,1,0,0,4'b1100, 2,1,4'b1100,0);
    vt[6]  = mk(1,0,4'b1111,8'h50,8'h54, 1, 1,8'h50,0,0,0,4'b0000, 0,1,4'b1100,0);
    vt[7]  = mk(1,0,4'b1000,8'h60,8'h64, 1, 1,8'h60,1,0,0,4'b1000, 2,2,4'b1000,0);
    vt[8]  = mk(0,1,4'b0000,8'h00,8'h00, 1, 1,8'h64,0,0,1,4'b0000, 2,2,4'b0100,0);
    vt[9]  = mk(0,1,4'b0000,8'h00,8'h00, 1, 0,8'h00,0,1,0,4'b0000, 2,1,4'b1100,0);
    vt[10] = mk(0,1,4'b0000,8'h00,8'h00, 1, 1,8'h44,0,0,1,4'b0000, 2,1,4'b0011,0);
    vt[11] = mk(0,1,4'b0000,8'h00,8'h00, 1, 0,8'h00,0,1,0,4'b0000, 2,0,4'b1111,0);

    // Reset state
    do_reset();
    chk("rst_push", ps_push, 0);
    chk("rst_pop", ps_pop, 0);
    chk("rst_comp", ps_comp, 0);
    chk("rst_redir_valid", pc_redir_valid, 0);
    chk("rst_redir", pc_redir, 0);
    chk("rst_ps_d", ps_d, 0);
    chk("rst_stall", stall, 0);
    chk("rst_depth", depth, 0);
    chk("rst_err", err, 0);
    chk("rst_mask", active_mask, 4'b1111);

    // Uniform, not-taken, divergent if/else, and nested unwinding
    for (int i = 0; i < 12; i++) apply_vec(vt[i]);

    // Overflow: with a fixed all-ones stack top every 1010 branch diverges
    do_reset();
    frc_en = 1'b1; frc_val = 4'b1111;
    for (int k = 0; k < 4; k++)
      apply_vec(mk(1,0,4'b1010,8'h80 + 8'(k),8'h90 + 8'(k), 1, 1,8'h80 + 8'(k),1,0,0,4'b1010,
                   2,DW'(k + 1),4'b1111,0));
    apply_vec(mk(1,0,4'b1010,8'hA0,8'hA4, 0, 0,8'h00,0,0,0,4'b0000, 0,4,4'b1111,1));
    // err stays set while normal work continues at the deepest level
    apply_vec(mk(0,1,4'b0000,8'h00,8'h00, 1, 1,8'h93,0,0,1,4'b0000, 2,4,4'b1111,1));
    do_reset();
    chk("err_cleared_by_reset", err, 0);

    // Join with nothing open
    apply_vec(mk(0,1,4'b0000,8'h00,8'h00, 0, 0,8'h00,0,0,0,4'b0000, 0,0,4'b1111,1));
    tick();
    tick();
    chk("underflow_output_missing", sb.size(), 0);

    // Branch and join together
    do_reset();
    apply_vec(mk(1,1,4'b1111,8'hB0,8'hB4, 0, 0,8'h00,0,0,0,4'b0000, 0,0,4'b1111,1));

    // Reset during the push cycle aborts the sequence
    do_reset();
    br_valid = 1'b1; br_pred = 4'b1010; br_target = 8'h10; br_fall = 8'h08;
    sb.push_back(mk(0,0,0,0,0, 1, 1,8'h10,1,0,0,4'b1010, 0,0,0,0).o);
    tick();
    br_valid = 1'b0;
    chk("op_stall", stall, 1);
    reset = 1'b1;
    tick();
    chk("abort_push", ps_push, 0);
    chk("abort_redir_valid", pc_redir_valid, 0);
    chk("abort_stall", stall, 0);
    chk("abort_depth", depth, 0);
    reset = 1'b0;
    tick();
    chk("abort_no_pulse", {ps_push, ps_pop, ps_comp, pc_redir_valid}, 0);
    chk("abort_mask", active_mask, 4'b1111);
    chk("abort_output_missing", sb.size(), 0);
    $display("[TB] vec %0d reset during OP -> depth=%0d stall=%0b", vnum, depth, stall);
    vnum++;

    // Branch held during OP/SETTLE is ignored
    br_valid = 1'b1; br_pred = 4'b1010; br_target = 8'h10; br_fall = 8'h08;
    sb.push_back(mk(0,0,0,0,0, 1, 1,8'h10,1,0,0,4'b1010, 0,0,0,0).o);
    tick();
    br_pred = 4'b1111; br_target = 8'h99;
    tick();
    tick();
    br_valid = 1'b0;
    tick();
    tick();
    chk("ignore_depth", depth, 1);
    chk("ignore_mask", active_mask, 4'b1010);
    chk("ignore_stall", stall, 0);
    chk("ignore_output_missing", sb.size(), 0);
    $display("[TB] vec %0d branch during stall -> depth=%0d mask=%b", vnum, depth, active_mask);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
